// File: rtl/boot_pkg.sv
// Shared types and constants for the bootstrap word FIFO.
// Holds the FSM state encoding, downstream write-enable codes and default sizes.
package boot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SLOT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] WE_SLOT = 2'b11;
  localparam logic [1:0] WE_IDLE = 2'b00;

  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned BYTE_WIDTH_DEF  = 8;
  localparam int unsigned DEPTH_LOG2_DEF  = 4;
  localparam int unsigned COUNT_WIDTH_DEF = 22;
  localparam int unsigned SLOT_CYCLES_DEF = 64;

endpackage

// File: rtl/boot_word_fifo_if.sv
// Loader / SRAM-writer facing signal bundle of boot_word_fifo.
// slave = the FIFO block itself, master = whoever drives the loader and pop side.
interface boot_word_fifo_if
  import boot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned BYTE_WIDTH  = BYTE_WIDTH_DEF,
  parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF
);

  logic                   load_start_i;
  logic [COUNT_WIDTH-1:0] load_len_i;
  logic [BYTE_WIDTH-1:0]  byte_data_i;
  logic                   byte_valid_i;
  logic                   read_fifo_i;
  logic [DATA_WIDTH-1:0]  fifo_dataout_o;
  logic [1:0]             write_enable_o;
  logic                   fifo_empty_o;
  logic                   fifo_full_o;
  logic [DEPTH_LOG2:0]    fifo_level_o;
  logic                   overflow_o;
  logic                   busy_o;
  logic                   done_o;

  modport slave (
    input  load_start_i, load_len_i, byte_data_i, byte_valid_i, read_fifo_i,
    output fifo_dataout_o, write_enable_o, fifo_empty_o, fifo_full_o,
           fifo_level_o, overflow_o, busy_o, done_o
  );

  modport master (
    output load_start_i, load_len_i, byte_data_i, byte_valid_i, read_fifo_i,
    input  fifo_dataout_o, write_enable_o, fifo_empty_o, fifo_full_o,
           fifo_level_o, overflow_o, busy_o, done_o
  );

endinterface

// File: rtl/boot_fifo_mem.sv
// Circular word buffer with extra-MSB pointers and a registered read port.
// Pushes while full and pops while empty are ignored; flush wins over both.
module boot_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  push_ok_c;
  logic                  pop_ok_c;

  // Equal pointers mean empty; same index with differing wrap bit means full.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign push_ok_c  = push_i && !full_o && !flush_i;
  assign pop_ok_c   = pop_i && !empty_o && !flush_i;
  assign pop_data_o = rd_data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_c) begin
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        rd_data_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
      end
    end
  end

  // Storage array carries no reset; only pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok_c) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/boot_word_fifo.sv
// Bootstrap write-path front end: packs loader bytes big-endian into words,
// buffers them, and paces the SRAM writer with one fixed-length slot per word.
module boot_word_fifo
  import boot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned BYTE_WIDTH  = BYTE_WIDTH_DEF,
  parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int unsigned SLOT_CYCLES = SLOT_CYCLES_DEF
) (
  input logic            boot_word_fifo_clk_i,
  input logic            boot_word_fifo_rst_n_i,
  boot_word_fifo_if.slave bus
);

  localparam int unsigned HOLD_W     = DATA_WIDTH - BYTE_WIDTH;
  localparam int unsigned SLOT_CNT_W = $clog2(SLOT_CYCLES);

  state_e                 state_q;
  logic [1:0]             byte_idx_q;
  logic [HOLD_W-1:0]      hold_q;
  logic [SLOT_CNT_W-1:0]  slot_cnt_q;
  logic [COUNT_WIDTH-1:0] word_done_q;
  logic [COUNT_WIDTH-1:0] len_q;
  logic                   popped_q;
  logic                   overflow_q;
  logic                   busy_q;
  logic                   done_q;
  logic [1:0]             we_q;

  logic                   flush_c;
  logic                   byte_take_c;
  logic                   push_c;
  logic                   pop_c;
  logic                   fifo_empty_c;
  logic                   fifo_full_c;
  logic [DEPTH_LOG2:0]    fifo_level_c;
  logic [DATA_WIDTH-1:0]  push_word_c;
  logic [DATA_WIDTH-1:0]  fifo_rd_data_c;
  logic [COUNT_WIDTH-1:0] word_done_inc_c;
  logic                   slot_last_c;

  // A load pulse overrides any same-cycle byte or pop.
  assign flush_c         = bus.load_start_i;
  assign byte_take_c     = bus.byte_valid_i && busy_q && !flush_c;
  assign push_c          = byte_take_c && (byte_idx_q == 2'd3);
  assign push_word_c     = {hold_q, bus.byte_data_i};
  assign pop_c           = (state_q == SLOT) && bus.read_fifo_i && !popped_q &&
                           !fifo_empty_c && !flush_c;
  assign word_done_inc_c = word_done_q + COUNT_WIDTH'(1);
  assign slot_last_c     = (slot_cnt_q == SLOT_CNT_W'(SLOT_CYCLES - 1));

  boot_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo_mem (
    .clk_i       (boot_word_fifo_clk_i),
    .rst_n_i     (boot_word_fifo_rst_n_i),
    .flush_i     (flush_c),
    .push_i      (push_c),
    .push_data_i (push_word_c),
    .pop_i       (pop_c),
    .pop_data_o  (fifo_rd_data_c),
    .full_o      (fifo_full_c),
    .empty_o     (fifo_empty_c),
    .level_o     (fifo_level_c)
  );

  // Packer, slot sequencer and completion tracking.
  always_ff @(posedge boot_word_fifo_clk_i or negedge boot_word_fifo_rst_n_i) begin
    if (!boot_word_fifo_rst_n_i) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      hold_q      <= '0;
      slot_cnt_q  <= '0;
      word_done_q <= '0;
      len_q       <= '0;
      popped_q    <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= WE_IDLE;
    end else if (flush_c) begin
      byte_idx_q  <= '0;
      slot_cnt_q  <= '0;
      word_done_q <= '0;
      len_q       <= bus.load_len_i;
      popped_q    <= 1'b0;
      overflow_q  <= 1'b0;
      we_q        <= WE_IDLE;
      if (bus.load_len_i == '0) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        state_q <= FILL;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end
    end else begin
      if (byte_take_c) begin
        byte_idx_q <= byte_idx_q + 2'd1;
        hold_q     <= {hold_q[HOLD_W-BYTE_WIDTH-1:0], bus.byte_data_i};
      end
      if (push_c && fifo_full_c) overflow_q <= 1'b1;
      if (pop_c) popped_q <= 1'b1;

      unique case (state_q)
        FILL: begin
          if (!fifo_empty_c) begin
            state_q    <= SLOT;
            slot_cnt_q <= '0;
            popped_q   <= 1'b0;
            we_q       <= WE_SLOT;
          end
        end
        SLOT: begin
          if (slot_last_c) begin
            word_done_q <= word_done_inc_c;
            we_q        <= WE_IDLE;
            if (word_done_inc_c == len_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= FILL;
            end
          end else begin
            slot_cnt_q <= slot_cnt_q + SLOT_CNT_W'(1);
          end
        end
        IDLE, DONE: state_q <= state_q;
        default:    state_q <= IDLE;
      endcase
    end
  end

  assign bus.fifo_dataout_o = fifo_rd_data_c;
  assign bus.write_enable_o = we_q;
  assign bus.fifo_empty_o   = fifo_empty_c;
  assign bus.fifo_full_o    = fifo_full_c;
  assign bus.fifo_level_o   = fifo_level_c;
  assign bus.overflow_o     = overflow_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;

endmodule
